pb_pan_ctrl: RTL and testbench

PB_PAN_CTRL -- requirements
Module: pb_pan_ctrl

---
 rtl/pb_pan_ctrl.sv | 149 ++++++++++++++
 tb/tb_pb_pan_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pb_pan_ctrl.sv
// Push-button pan controller: synchronize and debounce three buttons, step a saturating pan value, toggle a mode bit.
// Optional PB_PAN_AUTOREPEAT_EN adds hold-to-repeat stepping; without it each press yields exactly one step.
module pb_pan_ctrl #(
  parameter int DEBOUNCE_CYC   = 4,
  parameter int REPEAT_DLY_CYC = 10,
  parameter int REPEAT_PER_CYC = 3,
  parameter int PAN_W          = 3,
  parameter int PAN_MAX        = 7,
  parameter int PAN_INIT       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pb_left,
  input  logic             pb_right,
  input  logic             pb_mode,
  output logic [PAN_W-1:0] pan,
  output logic             pan_upd,
  output logic             mode
);

  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CW-1:0]    DB_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [PAN_W-1:0] P_MAX   = PAN_W'(PAN_MAX);
  localparam logic [PAN_W-1:0] P_INIT  = PAN_W'(PAN_INIT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
`ifdef PB_PAN_AUTOREPEAT_EN
  localparam logic [1:0] RPT  = 2'd2;
  localparam int RMAX = (REPEAT_DLY_CYC > REPEAT_PER_CYC) ? REPEAT_DLY_CYC : REPEAT_PER_CYC;
  localparam int TW   = $clog2(RMAX) + 1;
  localparam logic [TW-1:0] T_DLY = TW'(REPEAT_DLY_CYC);
  localparam logic [TW-1:0] T_PER = TW'(REPEAT_PER_CYC);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  logic [TW-1:0] timer, timer_n;
`endif

  logic [2:0] raw, db;
  assign raw = {pb_mode, pb_right, pb_left};

  // db changes only after DEBOUNCE_CYC consecutive disagreeing samples
  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic          s1, s2, d;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        d   <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
        if (s2 != d) begin
          if (cnt == DB_LAST) begin
            d   <= s2;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
    assign db[g] = d;
  end

  logic db_left, db_right, db_mode, db_mode_q;
  assign db_left  = db[0];
  assign db_right = db[1];
  assign db_mode  = db[2];

  logic [1:0] state, state_n;
  logic       dir, dir_n, step, step_right, held, both;

  assign both = db_left & db_right;
  assign held = dir ? db_right : db_left;

  always_comb begin
    state_n    = state;
    dir_n      = dir;
    step       = 1'b0;
    step_right = dir;
`ifdef PB_PAN_AUTOREPEAT_EN
    timer_n    = timer;
`endif
    case (state)
      IDLE: begin
        if (db_left ^ db_right) begin
          step       = 1'b1;
          step_right = db_right;
          dir_n      = db_right;
          state_n    = HOLD;
`ifdef PB_PAN_AUTOREPEAT_EN
          timer_n    = T_DLY;
`endif
        end
      end
      default: begin
        if (!held || both) begin
          state_n = IDLE;
`ifdef PB_PAN_AUTOREPEAT_EN
        end else if (timer == T_ONE) begin
          step    = 1'b1;
          timer_n = T_PER;
          state_n = RPT;
        end else begin
          timer_n = timer - 1'b1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= 1'b0;
`ifdef PB_PAN_AUTOREPEAT_EN
      timer     <= '0;
`endif
      pan       <= P_INIT;
      pan_upd   <= 1'b0;
      mode      <= 1'b0;
      db_mode_q <= 1'b0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
`ifdef PB_PAN_AUTOREPEAT_EN
      timer     <= timer_n;
`endif
      pan_upd   <= 1'b0;
      // saturation suppresses both the value change and the pulse
      if (step) begin
        if (step_right && pan != P_MAX) begin
          pan     <= pan + 1'b1;
          pan_upd <= 1'b1;
        end else if (!step_right && pan != '0) begin
          pan     <= pan - 1'b1;
          pan_upd <= 1'b1;
        end
      end
      db_mode_q <= db_mode;
      if (db_mode && !db_mode_q) mode <= ~mode;
    end
  end

endmodule

// File: tb/tb_pb_pan_ctrl.sv
// Scoreboard bench for pb_pan_ctrl: a press/age reference model queues expected pan and mode events,
// a monitor pops and compares them whenever the DUT pulses pan_upd or changes mode.
module tb_pb_pan_ctrl;
  localparam int D     = 4;
  localparam int RD    = 10;
  localparam int RP    = 3;
  localparam int PMAX  = 7;
  localparam int PINIT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pb_left = 1'b0, pb_right = 1'b0, pb_mode = 1'b0;
  logic [2:0] pan;
  logic       pan_upd, mode;

  pb_pan_ctrl #(
    .DEBOUNCE_CYC(D), .REPEAT_DLY_CYC(RD), .REPEAT_PER_CYC(RP),
    .PAN_W(3), .PAN_MAX(PMAX), .PAN_INIT(PINIT)
  ) dut (
    .clk(clk), .rst(rst), .pb_left(pb_left), .pb_right(pb_right), .pb_mode(pb_mode),
    .pan(pan), .pan_upd(pan_upd), .mode(mode)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  typedef struct { int e; int v; } ev_t;
  ev_t pan_q[$];
  ev_t mode_q[$];

  int total = 0;
  int bad   = 0;
  bit armed = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  // Reference model: sync delay line, run-length debounce, then press/age stepping.
  bit m_s1[3], m_s2[3], m_db[3];
  int m_run[3];
  bit m_dbq;
  int m_hold;   // 0 none, 1 left, 2 right
  int m_age;
  int m_pan;
  bit m_mode;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0;
    end
    m_dbq = 0; m_hold = 0; m_age = 0; m_pan = PINIT; m_mode = 0;
  endtask

  task automatic model_edge(input bit l, input bit r, input bit m, input bit rs);
    bit step;
    int dir, np;
    bit raw[3];
    int e;
    e = edge_n + 1;
    raw[0] = l; raw[1] = r; raw[2] = m;
    if (rs) begin
      model_reset();
      return;
    end
    step = 0;
    dir  = 0;
    if (m_hold == 0) begin
      if (m_db[0] != m_db[1]) begin
        step = 1;
        dir = m_db[1] ? 2 : 1;
        m_hold = dir;
        m_age = 0;
      end
    end else if (!((m_hold == 1) ? m_db[0] : m_db[1]) || (m_db[0] && m_db[1])) begin
      m_hold = 0;
    end else begin
      m_age++;
`ifdef PB_PAN_AUTOREPEAT_EN
      if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) begin
        step = 1;
        dir = m_hold;
      end
`endif
    end
    if (step) begin
      np = (dir == 2) ? ((m_pan < PMAX) ? m_pan + 1 : PMAX) : ((m_pan > 0) ? m_pan - 1 : 0);
      if (np != m_pan) pan_q.push_back('{e, np});
      m_pan = np;
    end
    if (m_db[2] && !m_dbq) begin
      m_mode = !m_mode;
      mode_q.push_back('{e, int'(m_mode)});
    end
    m_dbq = m_db[2];
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_db[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endtask

  task automatic tick(input bit l, input bit r, input bit m, input bit rs);
    @(negedge clk);
    pb_left = l; pb_right = r; pb_mode = m; rst = rs;
    model_edge(l, r, m, rs);
    @(posedge clk);
  endtask

  task automatic hold(input bit l, input bit r, input bit m, input int n);
    for (int i = 0; i < n; i++) tick(l, r, m, 1'b0);
  endtask

  // Monitor: samples 1 time unit after each active edge.
  logic mode_prev;
  always @(posedge clk) begin
    ev_t ev;
    #1;
    if (armed) begin
      if (rst) begin
        check("rst_pan", int'(pan), PINIT);
        check("rst_pan_upd", int'(pan_upd), 0);
        check("rst_mode", int'(mode), 0);
      end else begin
        while (pan_q.size() > 0 && pan_q[0].e < edge_n) begin
          ev = pan_q.pop_front();
          check("missed_pan_upd_edge", edge_n, ev.e);
        end
        if (pan_upd === 1'b1) begin
          if (pan_q.size() == 0) begin
            check("unexpected_pan_upd", 1, 0);
          end else begin
            ev = pan_q.pop_front();
            check("pan_upd_edge", edge_n, ev.e);
            check("pan_value", int'(pan), ev.v);
          end
        end
        while (mode_q.size() > 0 && mode_q[0].e < edge_n) begin
          ev = mode_q.pop_front();
          check("missed_mode_edge", edge_n, ev.e);
        end
        if (mode !== mode_prev) begin
          if (mode_q.size() == 0) begin
            check("unexpected_mode_change", 1, 0);
          end else begin
            ev = mode_q.pop_front();
            check("mode_edge", edge_n, ev.e);
            check("mode_value", int'(mode), ev.v);
          end
        end
      end
      mode_prev = mode;
    end
  end

  initial begin
    model_reset();
    tick(0, 0, 0, 1);
    armed = 1;
    tick(0, 0, 0, 1);
    // short glitch
    hold(0, 1, 0, 3);
    hold(0, 0, 0, 10);
    // long right hold
    hold(0, 1, 0, 30);
    hold(0, 0, 0, 10);
    // repeated short left presses down to 0
    for (int k = 0; k < 8; k++) begin
      hold(1, 0, 0, 8);
      hold(0, 0, 0, 8);
    end
    hold(1, 0, 0, 60);
    hold(0, 0, 0, 8);
    hold(1, 0, 0, 10);
    hold(0, 0, 0, 8);
    // simultaneous press, then release left
    hold(1, 1, 0, 12);
    hold(0, 1, 0, 12);
    hold(0, 0, 0, 8);
    // two mode presses
    for (int k = 0; k < 2; k++) begin
      hold(0, 0, 1, 8);
      hold(0, 0, 0, 8);
    end
    // reset during a right hold
    hold(0, 1, 0, 25);
    tick(0, 1, 0, 1);
    hold(0, 1, 0, 12);
    hold(0, 0, 0, 8);
    // random segments
    for (int s = 0; s < 60; s++) begin
      int pat, len;
      pat = $urandom_range(0, 7);
      len = $urandom_range(1, 25);
      if ($urandom_range(0, 19) == 0) tick(0, 0, 0, 1);
      hold(pat[0], pat[1], pat[2], len);
    end
    hold(0, 0, 0, 12);
    check("pending_pan_events", pan_q.size(), 0);
    check("pending_mode_events", mode_q.size(), 0);
    check("final_pan", int'(pan), m_pan);
    check("final_mode", int'(mode), int'(m_mode));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
